sdr_cmd_arb: RTL and testbench
==============================

// Module: sdr_cmd_arb
// PURPOSE
//  SDRAM command arbiter between the init/refresh engine (upstream) and the read/write burst engine.
//  Queues refresh requests and answers them with Sdr_ref_ack only at a burst boundary.
//  Reports bus ownership on Sdr_rw_vld and muxes the winning command onto the SDRAM pins.
// PARAMETERS
//  BA_WIDTH      2   bank address width (= `BA_WIDTH)
//  ROW_WIDTH     12  row addr MSB index; addr bus is [ROW_WIDTH:0] (= `ROW_WIDTH)
//  REF_PEND_MAX  8   saturation value of the pending-refresh counter
//  REF_TMO       32  cycles in S_REF without Sdr_init_ref_vld before forced exit
// PORTS
//  Sdr_clk            in   1       system SDRAM clock
//  Rst_n              in   1       async active-low reset
//  Sdr_init_done      in   1       init sequence complete (level)
//  Sdr_ref_req        in   1       refresh request (pulse or level; rising edge counted)
//  Sdr_ref_ack        out  1       1-cycle refresh grant to init/ref engine
//  Sdr_rw_vld         out  1       rw engine owns bus (=state S_RW)
//  Sdr_init_ref_vld   in   1       init/ref engine driving a command
//  Sdr_init_ref_ras/cas/we in 1 each  init/ref command (active-low SDRAM encoding)
//  Sdr_init_ref_ba    in   BA_WIDTH
//  Sdr_init_ref_addr  in   ROW_WIDTH+1
//  Rw_req             in   1       rw engine wants bus (level)
//  Rw_gnt             out  1       rw engine granted (=Sdr_rw_vld)
//  Rw_done            in   1       1-cycle pulse: burst incl. precharge finished
//  Rw_ras/cas/we      in   1 each  rw command (active-low)
//  Rw_ba / Rw_addr    in   BA_WIDTH / ROW_WIDTH+1
//  Sdr_cke            out  1       clock enable
//  Sdr_ras_n/cas_n/we_n out 1 each SDRAM command pins
//  Sdr_ba / Sdr_addr  out  BA_WIDTH / ROW_WIDTH+1
//  Ref_ovf            out  1       sticky: refresh lost (saturation or timeout)
// BEHAVIOUR
//  Reset: state=S_INIT, pend=0; Sdr_ref_ack=0, Sdr_rw_vld=Rw_gnt=0, Ref_ovf=0, Sdr_cke=0.
//  Reset: pins=NOP (ras_n=cas_n=we_n=1), Sdr_ba=0, Sdr_addr=0. Sdr_cke=1 from first clock after reset.
//  pend: +1 on Sdr_ref_req rising edge, -1 on exit from S_REF; simultaneous +1/-1 -> unchanged.
//  pend at REF_PEND_MAX with +1 -> hold, Ref_ovf=1. Ref_ovf cleared only by reset.
//  FSM (state and Sdr_ref_ack registered; both update on the same edge):
//   S_INIT: init path -> pins. Sdr_init_done=1 and Sdr_init_ref_vld=0 -> S_IDLE.
//   S_IDLE: pend>0 -> S_REF with Sdr_ref_ack=1 (refresh wins over Rw_req).
//           else Rw_req -> S_RW.
//   S_RW: rw path -> pins. On Rw_done: pend>0 -> S_REF+ack; else Rw_req -> stay; else S_IDLE.
//         A refresh never preempts a burst.
//   S_REF: init path -> pins when Sdr_init_ref_vld, else NOP. Exit to S_IDLE (pend-1):
//          - on Sdr_init_ref_vld falling edge, or
//          - REF_TMO cycles with no vld seen; timeout also sets Ref_ovf.
//  Sdr_rw_vld=0 in the ack cycle; the init/ref engine samples ack & !rw_vld.
//  Sdr_init_done falling in any state -> S_INIT next cycle. Grant drops at once, pend cleared.
//  Rw_done outside S_RW is ignored.
//  Pins carry NOP whenever no path is selected.
// CONFIGURATION
//  SDR_CMD_OUT_REG_EN defined: pin mux registered in IOB-style flops; command latency 1 clk.
//   Pins reset to NOP.
//  SDR_CMD_OUT_REG_EN undefined: pins are a combinational mux of the registered state;
//   latency 0; no extra flops.
//  FSM timing is identical in both builds.
// STRUCTURE
//  global_def.v holds:
//   - `BA_WIDTH, `ROW_WIDTH
//   - `SDR_CMD_NOP = 3'b111
//   - state encodings S_INIT=0, S_IDLE=1, S_RW=2, S_REF=3
//  Sub-module sdr_ref_pend_cnt: edge detect, saturating up/down counter, overflow flag.
//  Top level: FSM, timeout counter, output mux/register.
// TESTING
//  1 Reset, hold Sdr_init_done=0, drive init cmds.
//    -> pins follow init path; Rw_req=1 ignored; S_IDLE 1 clk after done=1 & vld=0.
//  2 Idle, Sdr_ref_req pulse.
//    -> Sdr_ref_ack pulse 1 clk later with Sdr_rw_vld=0; vld 1 for 20 clks then 0
//    -> back to S_IDLE, pend=0.
//  3 Rw burst active, Sdr_ref_req pulsed 3x.
//    -> no ack until Rw_done; then ack, 3 back-to-back refreshes before next grant.
//  4 9 ref_req edges while Rw_req is held and Rw_done is withheld.
//    -> pend=8 saturates, Ref_ovf=1.
//  5 In S_REF, vld never asserted.
//    -> exit after 32 clks, Ref_ovf=1, pend decremented.
//  6 Drop Sdr_init_done mid-burst.
//    -> Rw_gnt=0 next clk, S_INIT, pend=0; both macro builds, pins NOP/init per latency.

Source files
------------

// File: rtl/sdr_cmd_arb_pkg.sv
// Shared definitions for the SDRAM command arbiter: default widths, limits,
// the NOP command encoding and the arbiter state encoding.
package sdr_cmd_arb_pkg;

    localparam int DEF_BA_WIDTH     = 2;
    localparam int DEF_ROW_WIDTH    = 12;
    localparam int DEF_REF_PEND_MAX = 8;
    localparam int DEF_REF_TMO      = 32;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] SDR_CMD_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_RW   = 2'd2,
        S_REF  = 2'd3
    } state_e;

endpackage

// File: rtl/sdr_ref_pend_cnt.sv
// Pending-refresh bookkeeping: rising-edge detect on the request, saturating
// up/down counter and a sticky overflow flag (saturation or refresh timeout).
module sdr_ref_pend_cnt #(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ref_req,
    input  logic         clr,
    input  logic         dec,
    input  logic         tmo_ovf,
    output logic [W-1:0] pend,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic         req_q, req_d;
    logic [W-1:0] pend_q, pend_d;
    logic         ovf_q, ovf_d;
    logic         rise;

    always_comb begin
        req_d  = ref_req;
        rise   = ref_req & ~req_q;
        pend_d = pend_q;
        ovf_d  = ovf_q | tmo_ovf;
        if (clr) begin
            pend_d = '0;
        end else if (rise && !dec) begin
            // A request arriving at saturation is dropped and remembered as lost.
            if (pend_q == MAX_V) ovf_d = 1'b1;
            else                 pend_d = pend_q + 1'b1;
        end else if (dec && !rise && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            req_q  <= req_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/sdr_cmd_arb.sv
// SDRAM command arbiter: refresh/burst FSM, refresh timeout and pin mux.
// Define SDR_CMD_OUT_REG_EN to register the command pins (1 clk latency).
module sdr_cmd_arb
    import sdr_cmd_arb_pkg::*;
#(
    parameter int BA_WIDTH     = DEF_BA_WIDTH,
    parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
    parameter int REF_PEND_MAX = DEF_REF_PEND_MAX,
    parameter int REF_TMO      = DEF_REF_TMO
) (
    input  logic                                  Sdr_clk,
    input  logic                                  Rst_n,
    input  logic                                  Sdr_init_done,
    input  logic                                  Sdr_ref_req,
    output logic                                  Sdr_ref_ack,
    output logic                                  Sdr_rw_vld,
    input  logic                                  Sdr_init_ref_vld,
    input  logic                                  Sdr_init_ref_ras,
    input  logic                                  Sdr_init_ref_cas,
    input  logic                                  Sdr_init_ref_we,
    input  logic [BA_WIDTH-1:0]                   Sdr_init_ref_ba,
    input  logic [ROW_WIDTH:0]                    Sdr_init_ref_addr,
    input  logic                                  Rw_req,
    output logic                                  Rw_gnt,
    input  logic                                  Rw_done,
    input  logic                                  Rw_ras,
    input  logic                                  Rw_cas,
    input  logic                                  Rw_we,
    input  logic [BA_WIDTH-1:0]                   Rw_ba,
    input  logic [ROW_WIDTH:0]                    Rw_addr,
    output logic                                  Sdr_cke,
    output logic                                  Sdr_ras_n,
    output logic                                  Sdr_cas_n,
    output logic                                  Sdr_we_n,
    output logic [BA_WIDTH-1:0]                   Sdr_ba,
    output logic [ROW_WIDTH:0]                    Sdr_addr,
    output logic                                  Ref_ovf,
    output logic [1:0]                            dbg_state,
    output logic [$clog2(REF_PEND_MAX+1)-1:0]     dbg_pend
);

    localparam int PEND_W = $clog2(REF_PEND_MAX + 1);
    localparam int TMO_W  = $clog2(REF_TMO);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REF_TMO - 1);

    state_e             state_q, state_d;
    logic               ack_q, ack_d;
    logic               cke_q, cke_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               seen_q, seen_d;
    logic               ref_exit, tmo_hit;
    logic [PEND_W-1:0]  pend;

    logic [2:0]         pin_cmd_d;
    logic [BA_WIDTH-1:0] pin_ba_d;
    logic [ROW_WIDTH:0] pin_addr_d;

    sdr_ref_pend_cnt #(.MAX(REF_PEND_MAX), .W(PEND_W)) u_pend (
        .clk     (Sdr_clk),
        .rst_n   (Rst_n),
        .ref_req (Sdr_ref_req),
        .clr     (!Sdr_init_done),
        .dec     (ref_exit),
        .tmo_ovf (tmo_hit),
        .pend    (pend),
        .ovf     (Ref_ovf)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        cke_d    = 1'b1;
        tmo_d    = tmo_q;
        seen_d   = seen_q;
        ref_exit = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            S_INIT: if (!Sdr_init_ref_vld) state_d = S_IDLE;
            S_IDLE: begin
                if (pend != '0) begin
                    state_d = S_REF;
                    ack_d   = 1'b1;
                end else if (Rw_req) begin
                    state_d = S_RW;
                end
            end
            S_RW: begin
                // Refresh is only taken at a burst boundary.
                if (Rw_done) begin
                    if (pend != '0) begin
                        state_d = S_REF;
                        ack_d   = 1'b1;
                    end else if (!Rw_req) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_REF: begin
                seen_d = seen_q | Sdr_init_ref_vld;
                if (seen_q && !Sdr_init_ref_vld) begin
                    ref_exit = 1'b1;
                end else if (!seen_q && !Sdr_init_ref_vld) begin
                    if (tmo_q == TMO_LAST) begin
                        ref_exit = 1'b1;
                        tmo_hit  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                if (ref_exit) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
        if (!Sdr_init_done) begin
            state_d  = S_INIT;
            ack_d    = 1'b0;
            ref_exit = 1'b0;
            tmo_hit  = 1'b0;
        end
        if (state_d != S_REF) begin
            tmo_d  = '0;
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge Sdr_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_INIT;
            ack_q   <= 1'b0;
            cke_q   <= 1'b0;
            tmo_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            cke_q   <= cke_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
        end
    end

    // No command reaches the pins before CKE has been raised.
    always_comb begin
        pin_cmd_d  = SDR_CMD_NOP;
        pin_ba_d   = '0;
        pin_addr_d = '0;
        if (cke_q) begin
            if (state_q == S_INIT || (state_q == S_REF && Sdr_init_ref_vld)) begin
                pin_cmd_d  = {Sdr_init_ref_ras, Sdr_init_ref_cas, Sdr_init_ref_we};
                pin_ba_d   = Sdr_init_ref_ba;
                pin_addr_d = Sdr_init_ref_addr;
            end else if (state_q == S_RW) begin
                pin_cmd_d  = {Rw_ras, Rw_cas, Rw_we};
                pin_ba_d   = Rw_ba;
                pin_addr_d = Rw_addr;
            end
        end
    end

`ifdef SDR_CMD_OUT_REG_EN
    logic [2:0]          pin_cmd_q;
    logic [BA_WIDTH-1:0] pin_ba_q;
    logic [ROW_WIDTH:0]  pin_addr_q;

    always_ff @(posedge Sdr_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pin_cmd_q  <= SDR_CMD_NOP;
            pin_ba_q   <= '0;
            pin_addr_q <= '0;
        end else begin
            pin_cmd_q  <= pin_cmd_d;
            pin_ba_q   <= pin_ba_d;
            pin_addr_q <= pin_addr_d;
        end
    end

    assign {Sdr_ras_n, Sdr_cas_n, Sdr_we_n} = pin_cmd_q;
    assign Sdr_ba   = pin_ba_q;
    assign Sdr_addr = pin_addr_q;
`else
    assign {Sdr_ras_n, Sdr_cas_n, Sdr_we_n} = pin_cmd_d;
    assign Sdr_ba   = pin_ba_d;
    assign Sdr_addr = pin_addr_d;
`endif

    assign Sdr_ref_ack = ack_q;
    assign Sdr_rw_vld  = (state_q == S_RW);
    assign Rw_gnt      = Sdr_rw_vld;
    assign Sdr_cke     = cke_q;
    assign dbg_state   = state_q;
    assign dbg_pend    = pend;

endmodule

// File: tb/tb_sdr_cmd_arb.sv
// Directed self-checking bench for sdr_cmd_arb: init hand-off, refresh grant,
// refresh queued behind a burst, saturation, refresh timeout and init abort.
module tb_sdr_cmd_arb;
    import sdr_cmd_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        ref_req = 1'b0;
    logic        init_vld = 1'b0;
    logic        init_ras = 1'b1, init_cas = 1'b1, init_we = 1'b1;
    logic [1:0]  init_ba = '0;
    logic [12:0] init_addr = '0;
    logic        rw_req = 1'b0;
    logic        rw_done = 1'b0;
    logic        rw_ras = 1'b1, rw_cas = 1'b1, rw_we = 1'b1;
    logic [1:0]  rw_ba = '0;
    logic [12:0] rw_addr = '0;

    logic        ref_ack, rw_vld, rw_gnt, cke, ras_n, cas_n, we_n, ref_ovf;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_pend;
    logic [17:0] pins;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [17:0] PINS_NOP = {3'b111, 2'd0, 13'h0000};

    always #5 clk = ~clk;

    sdr_cmd_arb dut (
        .Sdr_clk(clk), .Rst_n(rst_n), .Sdr_init_done(init_done), .Sdr_ref_req(ref_req),
        .Sdr_ref_ack(ref_ack), .Sdr_rw_vld(rw_vld), .Sdr_init_ref_vld(init_vld),
        .Sdr_init_ref_ras(init_ras), .Sdr_init_ref_cas(init_cas), .Sdr_init_ref_we(init_we),
        .Sdr_init_ref_ba(init_ba), .Sdr_init_ref_addr(init_addr), .Rw_req(rw_req),
        .Rw_gnt(rw_gnt), .Rw_done(rw_done), .Rw_ras(rw_ras), .Rw_cas(rw_cas), .Rw_we(rw_we),
        .Rw_ba(rw_ba), .Rw_addr(rw_addr), .Sdr_cke(cke), .Sdr_ras_n(ras_n), .Sdr_cas_n(cas_n),
        .Sdr_we_n(we_n), .Sdr_ba(ba), .Sdr_addr(addr), .Ref_ovf(ref_ovf),
        .dbg_state(dbg_state), .dbg_pend(dbg_pend)
    );

    assign pins = {ras_n, cas_n, we_n, ba, addr};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ref_pulse();
        ref_req = 1'b1;
        clk_n(1);
        ref_req = 1'b0;
        clk_n(1);
    endtask

    task automatic do_refresh();
        init_vld = 1'b1;
        clk_n(2);
        init_vld = 1'b0;
        clk_n(1);
    endtask

    task automatic init_seq();
        rst_n = 1'b0; init_done = 1'b0; init_vld = 1'b0;
        ref_req = 1'b0; rw_req = 1'b0; rw_done = 1'b0;
        clk_n(2);
        rst_n = 1'b1; init_done = 1'b1;
        clk_n(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and init phase: init path on the pins, burst request ignored
        {init_ras, init_cas, init_we} = 3'b011; init_ba = 2'd2; init_addr = 13'h0123;
        {rw_ras, rw_cas, rw_we} = 3'b100; rw_ba = 2'd1; rw_addr = 13'h0055;
        init_vld = 1'b1; rw_req = 1'b1;
        clk_n(2);
        check_eq("rst_cke", cke, 0);
        check_eq("rst_state", dbg_state, S_INIT);
        check_eq("rst_ack", ref_ack, 0);
        check_eq("rst_gnt", {rw_gnt, rw_vld}, 0);
        check_eq("rst_ovf", ref_ovf, 0);
        check_eq("rst_pins", pins, PINS_NOP);
        rst_n = 1'b1;
        clk_n(2);
        check_eq("init_cke", cke, 1);
        check_eq("init_state", dbg_state, S_INIT);
        check_eq("init_gnt", rw_gnt, 0);
        check_eq("init_pins", pins, {3'b011, 2'd2, 13'h0123});
        init_done = 1'b1;
        clk_n(1);
        check_eq("init_vld_hold", dbg_state, S_INIT);
        init_vld = 1'b0; rw_req = 1'b0;
        clk_n(1);
        check_eq("init_to_idle", dbg_state, S_IDLE);
        clk_n(1);
        check_eq("idle_pins", pins, PINS_NOP);

        // Single refresh from idle, init/ref engine drives for 20 clocks
        rw_done = 1'b1;
        clk_n(1);
        rw_done = 1'b0;
        check_eq("done_ignored", dbg_state, S_IDLE);
        ref_req = 1'b1;
        clk_n(1);
        ref_req = 1'b0;
        check_eq("ref_pend1", dbg_pend, 1);
        check_eq("ref_noack_yet", ref_ack, 0);
        clk_n(1);
        check_eq("ref_ack", {ref_ack, rw_vld}, 2'b10);
        check_eq("ref_state", dbg_state, S_REF);
        {init_ras, init_cas, init_we} = 3'b001; init_ba = 2'd0; init_addr = 13'h0400;
        init_vld = 1'b1;
        clk_n(1);
        check_eq("ref_ack_pulse", ref_ack, 0);
        check_eq("ref_pins", pins, {3'b001, 2'd0, 13'h0400});
        clk_n(19);
        check_eq("ref_hold", dbg_state, S_REF);
        init_vld = 1'b0;
        clk_n(1);
        check_eq("ref_exit", dbg_state, S_IDLE);
        check_eq("ref_pend0", dbg_pend, 0);
        check_eq("ref_ovf0", ref_ovf, 0);
        check_eq("ref_exit_pins", pins, PINS_NOP);

        // Three refreshes queued behind a burst
        rw_req = 1'b1;
        clk_n(2);
        check_eq("rw_gnt", {rw_gnt, rw_vld}, 2'b11);
        check_eq("rw_pins", pins, {3'b100, 2'd1, 13'h0055});
        repeat (3) ref_pulse();
        check_eq("rw_pend3", dbg_pend, 3);
        check_eq("rw_no_preempt", dbg_state, S_RW);
        check_eq("rw_noack", ref_ack, 0);
        rw_done = 1'b1;
        clk_n(1);
        rw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("b2b_ack", {ref_ack, rw_gnt, dbg_state}, {1'b1, 1'b0, S_REF});
            do_refresh();
            check_eq("b2b_pend", dbg_pend, 32'(2 - i));
            check_eq("b2b_idle", dbg_state, S_IDLE);
            clk_n(1);
        end
        check_eq("b2b_regrant", {rw_gnt, dbg_state}, {1'b1, S_RW});

        // Saturation while the burst withholds Rw_done
        repeat (8) ref_pulse();
        check_eq("sat_pend8", dbg_pend, 8);
        check_eq("sat_ovf0", ref_ovf, 0);
        ref_pulse();
        check_eq("sat_pend_hold", dbg_pend, 8);
        check_eq("sat_ovf1", ref_ovf, 1);
        check_eq("sat_still_rw", dbg_state, S_RW);

        // Init done drops mid-burst
        {init_ras, init_cas, init_we} = 3'b010; init_ba = 2'd3; init_addr = 13'h1fff;
        init_done = 1'b0;
        clk_n(1);
        check_eq("abort_gnt", rw_gnt, 0);
        check_eq("abort_state", dbg_state, S_INIT);
        check_eq("abort_pend", dbg_pend, 0);
        check_eq("abort_ovf_sticky", ref_ovf, 1);
`ifdef SDR_CMD_OUT_REG_EN
        check_eq("abort_pins_lat", pins, {3'b100, 2'd1, 13'h0055});
`else
        check_eq("abort_pins_lat", pins, {3'b010, 2'd3, 13'h1fff});
`endif
        clk_n(1);
        check_eq("abort_pins", pins, {3'b010, 2'd3, 13'h1fff});

        // Refresh timeout: init/ref engine never answers
        init_seq();
        check_eq("tmo_idle", dbg_state, S_IDLE);
        check_eq("tmo_ovf_rst", ref_ovf, 0);
        ref_pulse();
        check_eq("tmo_ack", {ref_ack, dbg_state}, {1'b1, S_REF});
        ref_pulse();
        check_eq("tmo_pend2", dbg_pend, 2);
        clk_n(29);
        check_eq("tmo_before", dbg_state, S_REF);
        check_eq("tmo_ovf_before", ref_ovf, 0);
        clk_n(1);
        check_eq("tmo_exit", dbg_state, S_IDLE);
        check_eq("tmo_ovf", ref_ovf, 1);
        check_eq("tmo_pend_dec", dbg_pend, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
